// File: rtl/count_sampler_pkg.sv
// Shared types and default sizing for the ripple-counter capture stage.
package count_sampler_pkg;

   // Default sizing of the capture path
   localparam int unsigned DEFAULT_WIDTH         = 4;
   localparam int unsigned DEFAULT_STABLE_CYCLES = 2;

   // States of the threshold-match interrupt machine
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FIRED = 2'd2
   } matchState_e;

endpackage : count_sampler_pkg

// File: rtl/sync_stabilizer.sv
// Two-flop synchroniser followed by a stability filter. A value is offered
// upstream (accept_o strobe) only after it has been seen unchanged at the
// synchroniser output for STABLE_CYCLES consecutive clocks, and only when it
// differs from the value last accepted (or nothing has been accepted yet).
module sync_stabilizer
   import count_sampler_pkg::*;
#(
   parameter int unsigned WIDTH         = DEFAULT_WIDTH,
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] rawCount_i,
   input  logic [WIDTH-1:0] lastValue_i,
   input  logic             lastValid_i,
   output logic [WIDTH-1:0] value_o,
   output logic             accept_o
);

   localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
   localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

   logic [WIDTH-1:0]  sync1_q, sync2_q;
   logic [WIDTH-1:0]  cand_q, cand_d;
   logic [STAB_W-1:0] stab_q, stab_d;

   // Restart the stability count whenever the synchronised value moves,
   // otherwise count up and saturate at the required run length
   always_comb begin
      cand_d = cand_q;
      stab_d = stab_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         stab_d = STAB_ONE;
      end else if (stab_q < STAB_MAX) begin
         stab_d = stab_q + STAB_ONE;
      end
   end

   // Accept decision looks at the next-state values so the consumer can
   // register the new count on the same edge the filter becomes satisfied
   always_comb begin
      value_o  = cand_d;
      accept_o = (stab_d == STAB_MAX) && ((cand_d != lastValue_i) || !lastValid_i);
   end

   // Synchroniser chain and filter registers; the chain has no logic between
   // stages so metastability gets a full clock to resolve
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         stab_q  <= '0;
      end else begin
         sync1_q <= rawCount_i;
         sync2_q <= sync1_q;
         cand_q  <= cand_d;
         stab_q  <= stab_d;
      end
   end

endmodule : sync_stabilizer

// File: rtl/count_sampler.sv
// Capture stage for an asynchronous ripple counter: publishes the clean
// count, pulses on wrap-around and raises a threshold-match interrupt that is
// held until acknowledged, with a sticky overrun flag for missed matches.
module count_sampler
   import count_sampler_pkg::*;
#(
   parameter int unsigned WIDTH         = DEFAULT_WIDTH,
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             enable,
   input  logic [WIDTH-1:0] threshold,
   input  logic             irq_ack,
   output logic [WIDTH-1:0] count_out,
   output logic             count_valid,
   output logic             wrap_pulse,
   output logic             match_irq,
   output logic             irq_overrun
);

   logic [WIDTH-1:0] countOut_q;
   logic             countValid_q;
   logic             wrapPulse_q;
   logic [WIDTH-1:0] acceptValue;
   logic             acceptStrobe;
   logic             matchHit;

   matchState_e      state_q, state_d;
   logic             overrun_q, overrun_d;

   sync_stabilizer #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) uStabilizer (
      .clock       (clock),
      .reset       (reset),
      .rawCount_i  (count_in),
      .lastValue_i (countOut_q),
      .lastValid_i (countValid_q),
      .value_o     (acceptValue),
      .accept_o    (acceptStrobe)
   );

   assign matchHit = acceptStrobe && (acceptValue == threshold);

   // Publish accepted values; a wrap is only meaningful relative to a
   // previously published value, so the first acceptance never pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         countOut_q   <= '0;
         countValid_q <= 1'b0;
         wrapPulse_q  <= 1'b0;
      end else begin
         wrapPulse_q <= acceptStrobe && countValid_q && (acceptValue < countOut_q);
         if (acceptStrobe) begin
            countOut_q   <= acceptValue;
            countValid_q <= 1'b1;
         end
      end
   end

   // Match machine: arm on enable, fire on a matching acceptance, and leave
   // FIRED only through an acknowledge (a coincident new match keeps it FIRED)
   always_comb begin
      state_d   = state_q;
      overrun_d = overrun_q;
      unique case (state_q)
         IDLE: begin
            if (enable) state_d = ARMED;
         end
         ARMED: begin
            if (!enable)       state_d = IDLE;
            else if (matchHit) state_d = FIRED;
         end
         FIRED: begin
            if (irq_ack) begin
               if (!matchHit) begin
                  state_d   = enable ? ARMED : IDLE;
                  overrun_d = 1'b0;
               end
            end else if (matchHit) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            overrun_d = 1'b0;
         end
      endcase
   end

   // Match machine state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         overrun_q <= overrun_d;
      end
   end

   assign count_out   = countOut_q;
   assign count_valid = countValid_q;
   assign wrap_pulse  = wrapPulse_q;
   assign match_irq   = (state_q == FIRED);
   assign irq_overrun = overrun_q;

endmodule : count_sampler
